// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port memory between the fetch stage (IF, read-only) and
//   the memory stage (DM, read/write). Each access is a req/ready handshake on
//   the memory side. Each requester gets a one-cycle valid pulse with its data.
//   Per-stage stall outputs go to the pipeline. An access that waits too long
//   for mem_ready is aborted, so the pipeline can never hang.
//
// Parameters
//   AW       address width
//   DW       data width
//   TIMEOUT  SERVE cycles to wait for mem_ready before aborting (0 = forever)
//
// Configuration macro
//   ROUND_ROBIN_EN  when defined, simultaneous requests alternate between IF and
//                   DM. The default build gives DM fixed priority.
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-high reset
//   if_req/if_addr        fetch request, held stable until if_valid
//   if_rdata/if_valid     fetched word and its one-cycle completion pulse
//   dm_req/dm_we/dm_addr/dm_wdata  data request, held stable until dm_valid
//   dm_rdata/dm_valid     load data and its one-cycle completion pulse
//   mem_req/mem_we/mem_addr/mem_wdata  memory command, held until mem_ready
//   mem_rdata/mem_ready   memory read data and one-cycle completion
//   stall_f/stall_m       requester still waiting for its valid
//   err                   pulses with the valid of a timed-out access
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int TIMEOUT = 255
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          if_req,
  input  logic [AW-1:0] if_addr,
  output logic [DW-1:0] if_rdata,
  output logic          if_valid,
  input  logic          dm_req,
  input  logic          dm_we,
  input  logic [AW-1:0] dm_addr,
  input  logic [DW-1:0] dm_wdata,
  output logic [DW-1:0] dm_rdata,
  output logic          dm_valid,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  input  logic          mem_ready,
  output logic          stall_f,
  output logic          stall_m,
  output logic          err
);

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  // The abort happens in the SERVE cycle in which the counter already shows
  // TIMEOUT-1 earlier misses. That makes the TIMEOUT-th miss the last one.
  localparam logic [CW-1:0] LAST_WAIT = (TIMEOUT > 0) ? CW'(TIMEOUT - 1) : '0;

  typedef enum logic [1:0] {IDLE, SERVE_I, SERVE_D} state_t;

  state_t        r_state, w_stateNext;
  logic [CW-1:0] r_count, w_countNext;
  logic          r_memReq, w_memReqNext;
  logic          r_memWe, w_memWeNext;
  logic [AW-1:0] r_memAddr, w_memAddrNext;
  logic [DW-1:0] r_memWdata, w_memWdataNext;
  logic [DW-1:0] r_ifRdata, w_ifRdataNext;
  logic [DW-1:0] r_dmRdata, w_dmRdataNext;
  logic          r_ifValid, w_ifValidNext;
  logic          r_dmValid, w_dmValidNext;
  logic          r_err, w_errNext;
  logic          w_ifElig, w_dmElig, w_grantI, w_grantD, w_timeout;
`ifdef ROUND_ROBIN_EN
  logic          r_lastIf, w_lastIfNext;
`endif

  // A requester is not eligible in its own valid cycle. It only lowers its
  // request in the following cycle.
  assign w_ifElig = if_req & ~r_ifValid;
  assign w_dmElig = dm_req & ~r_dmValid;

`ifdef ROUND_ROBIN_EN
  // On a tie, DM wins only if IF was granted most recently.
  assign w_grantD = w_dmElig & (~w_ifElig | r_lastIf);
`else
  assign w_grantD = w_dmElig;
`endif
  assign w_grantI = w_ifElig & ~w_grantD;

  assign w_timeout = (TIMEOUT != 0) && (r_count == LAST_WAIT);

  // State and datapath registers; everything clears on reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= IDLE;
      r_count    <= '0;
      r_memReq   <= 1'b0;
      r_memWe    <= 1'b0;
      r_memAddr  <= '0;
      r_memWdata <= '0;
      r_ifRdata  <= '0;
      r_dmRdata  <= '0;
      r_ifValid  <= 1'b0;
      r_dmValid  <= 1'b0;
      r_err      <= 1'b0;
`ifdef ROUND_ROBIN_EN
      r_lastIf   <= 1'b1;
`endif
    end else begin
      r_state    <= w_stateNext;
      r_count    <= w_countNext;
      r_memReq   <= w_memReqNext;
      r_memWe    <= w_memWeNext;
      r_memAddr  <= w_memAddrNext;
      r_memWdata <= w_memWdataNext;
      r_ifRdata  <= w_ifRdataNext;
      r_dmRdata  <= w_dmRdataNext;
      r_ifValid  <= w_ifValidNext;
      r_dmValid  <= w_dmValidNext;
      r_err      <= w_errNext;
`ifdef ROUND_ROBIN_EN
      r_lastIf   <= w_lastIfNext;
`endif
    end
  end

  // Next-state logic. Valid and err are pulses, so they default low. The
  // memory command and the returned data hold their values.
  always_comb begin
    w_stateNext    = r_state;
    w_countNext    = r_count;
    w_memReqNext   = r_memReq;
    w_memWeNext    = r_memWe;
    w_memAddrNext  = r_memAddr;
    w_memWdataNext = r_memWdata;
    w_ifRdataNext  = r_ifRdata;
    w_dmRdataNext  = r_dmRdata;
    w_ifValidNext  = 1'b0;
    w_dmValidNext  = 1'b0;
    w_errNext      = 1'b0;
`ifdef ROUND_ROBIN_EN
    w_lastIfNext   = r_lastIf;
`endif
    case (r_state)
      IDLE: begin
        // mem_ready is ignored here; it only has meaning while mem_req is high.
        if (w_grantD) begin
          w_stateNext    = SERVE_D;
          w_memReqNext   = 1'b1;
          w_memWeNext    = dm_we;
          w_memAddrNext  = dm_addr;
          w_memWdataNext = dm_wdata;
          w_countNext    = '0;
`ifdef ROUND_ROBIN_EN
          w_lastIfNext   = 1'b0;
`endif
        end else if (w_grantI) begin
          w_stateNext    = SERVE_I;
          w_memReqNext   = 1'b1;
          w_memWeNext    = 1'b0;
          w_memAddrNext  = if_addr;
          w_countNext    = '0;
`ifdef ROUND_ROBIN_EN
          w_lastIfNext   = 1'b1;
`endif
        end
      end
      SERVE_I, SERVE_D: begin
        if (mem_ready) begin
          w_stateNext  = IDLE;
          w_memReqNext = 1'b0;
          if (r_state == SERVE_I) begin
            w_ifRdataNext = mem_rdata;
            w_ifValidNext = 1'b1;
          end else begin
            // Stores leave the last load data untouched.
            if (!r_memWe) w_dmRdataNext = mem_rdata;
            w_dmValidNext = 1'b1;
          end
        end else if (w_timeout) begin
          w_stateNext  = IDLE;
          w_memReqNext = 1'b0;
          w_errNext    = 1'b1;
          if (r_state == SERVE_I) begin
            w_ifRdataNext = '0;
            w_ifValidNext = 1'b1;
          end else begin
            w_dmRdataNext = '0;
            w_dmValidNext = 1'b1;
          end
        end else if (r_count != '1) begin
          w_countNext = r_count + 1'b1;
        end
      end
      default: w_stateNext = IDLE;
    endcase
  end

  assign mem_req   = r_memReq;
  assign mem_we    = r_memWe;
  assign mem_addr  = r_memAddr;
  assign mem_wdata = r_memWdata;
  assign if_rdata  = r_ifRdata;
  assign dm_rdata  = r_dmRdata;
  assign if_valid  = r_ifValid;
  assign dm_valid  = r_dmValid;
  assign err       = r_err;
  assign stall_f   = if_req & ~r_ifValid;
  assign stall_m   = dm_req & ~r_dmValid;

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
//   Directed scenarios plus a randomized phase for mem_arbiter (TIMEOUT = 4).
//   The expected outputs come from a transaction-level model: who owns the
//   memory, how long it has waited, and what each requester should see next.
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          if_req, dm_req, dm_we, mem_ready;
  logic [AW-1:0] if_addr, dm_addr;
  logic [DW-1:0] dm_wdata, mem_rdata;
  logic [DW-1:0] if_rdata, dm_rdata, mem_wdata;
  logic [AW-1:0] mem_addr;
  logic          if_valid, dm_valid, mem_req, mem_we, stall_f, stall_m, err;

  int vectors = 0;
  int miscompares = 0;

  // Reference model: owner 0 = memory free, 1 = IF, 2 = DM
  int            owner;
  int            waited;
  bit            lastWasIf;
  logic          eMemReq, eMemWe, eIfValid, eDmValid, eErr;
  logic [AW-1:0] eMemAddr;
  logic [DW-1:0] eMemWdata, eIfRdata, eDmRdata;

  // Random-phase agents
  bit autoMode = 1'b0;
  bit checkOn  = 1'b0;
  bit ifDrop, dmDrop, memActive;
  int memDelay;

  always #5 clk = ~clk;

  mem_arbiter #(.AW(AW), .DW(DW), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_valid(if_valid),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_rdata(dm_rdata), .dm_valid(dm_valid),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .stall_f(stall_f), .stall_m(stall_m), .err(err)
  );

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    owner = 0; waited = 0; lastWasIf = 1'b1;
    eMemReq = 0; eMemWe = 0; eIfValid = 0; eDmValid = 0; eErr = 0;
    eMemAddr = '0; eMemWdata = '0; eIfRdata = '0; eDmRdata = '0;
  endtask

  // Advance the model by one clock edge, using the inputs present in the cycle that just ended.
  task automatic modelStep();
    bit ifElig, dmElig, nIfV, nDmV, nErr;
    int pick;
    nIfV = 0; nDmV = 0; nErr = 0; pick = 0;
    if (owner == 0) begin
      ifElig = if_req && !eIfValid;
      dmElig = dm_req && !eDmValid;
      if (dmElig && ifElig) begin
`ifdef ROUND_ROBIN_EN
        pick = lastWasIf ? 2 : 1;
`else
        pick = 2;
`endif
      end else if (dmElig) pick = 2;
      else if (ifElig) pick = 1;
      if (pick == 2) begin
        owner = 2; waited = 0; eMemReq = 1; eMemWe = dm_we;
        eMemAddr = dm_addr; eMemWdata = dm_wdata; lastWasIf = 0;
      end else if (pick == 1) begin
        owner = 1; waited = 0; eMemReq = 1; eMemWe = 0;
        eMemAddr = if_addr; lastWasIf = 1;
      end
    end else if (mem_ready) begin
      if (owner == 1) begin eIfRdata = mem_rdata; nIfV = 1; end
      else begin
        if (!eMemWe) eDmRdata = mem_rdata;
        nDmV = 1;
      end
      owner = 0; eMemReq = 0;
    end else begin
      waited++;
      if (TO > 0 && waited >= TO) begin
        if (owner == 1) begin eIfRdata = '0; nIfV = 1; end
        else begin eDmRdata = '0; nDmV = 1; end
        nErr = 1; owner = 0; eMemReq = 0;
      end
    end
    eIfValid = nIfV; eDmValid = nDmV; eErr = nErr;
  endtask

  // Random requesters: each holds its request until its valid, then lowers it the next cycle.
  // The memory responds after 0..5 cycles; a delay of 4 or more forces a timeout.
  task automatic applyStimulus();
    if (ifDrop) begin if_req = 0; ifDrop = 0; end
    else if (if_req && if_valid) ifDrop = 1;
    else if (!if_req && $urandom_range(0, 2) == 0) begin
      if_req = 1; if_addr = $urandom() & 32'h0000_0FFC;
    end
    if (dmDrop) begin dm_req = 0; dmDrop = 0; end
    else if (dm_req && dm_valid) dmDrop = 1;
    else if (!dm_req && $urandom_range(0, 2) == 0) begin
      dm_req = 1; dm_we = $urandom_range(0, 1) == 1;
      dm_addr = $urandom() & 32'h0000_FFFC; dm_wdata = $urandom();
    end
    if (mem_req) begin
      if (!memActive) begin memActive = 1; memDelay = $urandom_range(0, 5); end
      if (memDelay == 0) begin mem_ready = 1; mem_rdata = $urandom(); memActive = 0; end
      else begin memDelay--; mem_ready = 0; end
    end else begin
      memActive = 0;
      mem_ready = ($urandom_range(0, 7) == 0);
      mem_rdata = $urandom();
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
    if (reset) modelReset(); else modelStep();
    if (autoMode) applyStimulus();
  endtask

  // Compare every DUT output against the model once per cycle, on the falling edge.
  initial forever begin
    @(negedge clk);
    if (checkOn && !reset) begin
      checkOutput("mem_req", mem_req, eMemReq);
      checkOutput("mem_we", mem_we, eMemWe);
      checkOutput("mem_addr", mem_addr, eMemAddr);
      if (eMemReq && eMemWe) checkOutput("mem_wdata", mem_wdata, eMemWdata);
      checkOutput("if_valid", if_valid, eIfValid);
      checkOutput("dm_valid", dm_valid, eDmValid);
      checkOutput("err", err, eErr);
      checkOutput("if_rdata", if_rdata, eIfRdata);
      checkOutput("dm_rdata", dm_rdata, eDmRdata);
      checkOutput("stall_f", stall_f, if_req & ~eIfValid);
      checkOutput("stall_m", stall_m, dm_req & ~eDmValid);
    end
  end

  initial begin
    reset = 1; if_req = 0; if_addr = '0; dm_req = 0; dm_we = 0; dm_addr = '0;
    dm_wdata = '0; mem_ready = 0; mem_rdata = '0;
    ifDrop = 0; dmDrop = 0; memActive = 0; memDelay = 0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_mem_req", mem_req, 1'b0);
    checkOutput("reset_if_valid", if_valid, 1'b0);
    checkOutput("reset_dm_rdata", dm_rdata, 32'h0);
    @(posedge clk); #1; reset = 0; checkOn = 1;

    // Reset asserted in the middle of a DM access
    tick(); dm_req = 1; dm_we = 0; dm_addr = 32'h10;
    tick(); @(negedge clk);
    checkOutput("A_mem_req", mem_req, 1'b1);
    checkOutput("A_mem_addr", mem_addr, 32'h10);
    #2 reset = 1; modelReset(); #1;
    checkOutput("A_async_mem_req", mem_req, 1'b0);
    checkOutput("A_async_mem_addr", mem_addr, 32'h0);
    checkOutput("A_async_dm_valid", dm_valid, 1'b0);
    checkOutput("A_async_err", err, 1'b0);
    dm_req = 0;
    tick(); reset = 0;
    tick(); @(negedge clk);
    checkOutput("A_idle_mem_req", mem_req, 1'b0);

    // IF-only fetch; mem_ready arrives 3 cycles after mem_req
    tick(); if_req = 1; if_addr = 32'h40;
    tick(); @(negedge clk);
    checkOutput("B_mem_req", mem_req, 1'b1);
    checkOutput("B_mem_we", mem_we, 1'b0);
    checkOutput("B_mem_addr", mem_addr, 32'h40);
    checkOutput("B_stall_f", stall_f, 1'b1);
    tick(); @(negedge clk);
    checkOutput("B_wait_if_valid", if_valid, 1'b0);
    tick();
    tick(); mem_ready = 1; mem_rdata = 32'h2002000A;
    tick(); mem_ready = 0; mem_rdata = '0; @(negedge clk);
    checkOutput("B_if_valid", if_valid, 1'b1);
    checkOutput("B_if_rdata", if_rdata, 32'h2002000A);
    checkOutput("B_stall_f_done", stall_f, 1'b0);
    tick(); if_req = 0; @(negedge clk);
    checkOutput("B_if_valid_pulse", if_valid, 1'b0);

    // Simultaneous requests: the DM store goes first, then IF
    tick(); dm_req = 1; dm_we = 1; dm_addr = 32'h80; dm_wdata = 32'h1234;
    if_req = 1; if_addr = 32'h44;
    tick(); mem_ready = 1; mem_rdata = 32'hDEADBEEF; @(negedge clk);
    checkOutput("C_mem_we", mem_we, 1'b1);
    checkOutput("C_mem_addr", mem_addr, 32'h80);
    checkOutput("C_mem_wdata", mem_wdata, 32'h1234);
    tick(); mem_ready = 0; @(negedge clk);
    checkOutput("C_dm_valid", dm_valid, 1'b1);
    checkOutput("C_dm_rdata_kept", dm_rdata, 32'h0);
    checkOutput("C_stall_f", stall_f, 1'b1);
    tick(); dm_req = 0; mem_ready = 1; mem_rdata = 32'h11111111; @(negedge clk);
    checkOutput("C_if_mem_req", mem_req, 1'b1);
    checkOutput("C_if_mem_addr", mem_addr, 32'h44);
    checkOutput("C_if_mem_we", mem_we, 1'b0);
    tick(); mem_ready = 0; @(negedge clk);
    checkOutput("C_if_rdata", if_rdata, 32'h11111111);
    tick(); if_req = 0;

    // A normal load, then a load that times out, then a normal load again
    tick(); dm_req = 1; dm_we = 0; dm_addr = 32'h90;
    tick(); mem_ready = 1; mem_rdata = 32'hCAFEF00D;
    tick(); mem_ready = 0; @(negedge clk);
    checkOutput("D_load_rdata", dm_rdata, 32'hCAFEF00D);
    tick(); dm_req = 0;
    tick(); dm_req = 1; dm_addr = 32'h94;
    for (int k = 0; k < 4; k++) begin
      tick(); @(negedge clk);
      checkOutput("D_wait_mem_req", mem_req, 1'b1);
    end
    tick(); @(negedge clk);
    checkOutput("D_to_mem_req", mem_req, 1'b0);
    checkOutput("D_to_dm_valid", dm_valid, 1'b1);
    checkOutput("D_to_err", err, 1'b1);
    checkOutput("D_to_dm_rdata", dm_rdata, 32'h0);
    tick(); dm_req = 0; @(negedge clk);
    checkOutput("D_err_pulse", err, 1'b0);
    tick(); dm_req = 1; dm_addr = 32'h98;
    tick(); mem_ready = 1; mem_rdata = 32'h0BADCAFE;
    tick(); mem_ready = 0; @(negedge clk);
    checkOutput("D_next_valid", dm_valid, 1'b1);
    checkOutput("D_next_rdata", dm_rdata, 32'h0BADCAFE);
    checkOutput("D_next_err", err, 1'b0);
    tick(); dm_req = 0;

    // Spurious mem_ready while idle
    tick(); mem_ready = 1; mem_rdata = 32'hFFFFFFFF;
    tick(); mem_ready = 0; @(negedge clk);
    checkOutput("E_if_valid", if_valid, 1'b0);
    checkOutput("E_dm_valid", dm_valid, 1'b0);
    checkOutput("E_mem_req", mem_req, 1'b0);

    // Randomized traffic against the model
    tick(); autoMode = 1;
    repeat (4000) tick();
    autoMode = 0;
    @(negedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
